// File: rtl/p6_mem_responder.sv
// Memory-side responder for p6 CPU load/store/fetch requests: 256x16 sync RAM plus
// LED and switch I/O registers, one request in flight, one-cycle response pulse.
module p6_mem_responder #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ready,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              resp_valid,
  output logic              err,
  input  logic [7:0]        sw_in,
  output logic [7:0]        ledr
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned IO_W   = 8;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACCESS = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] ram_rd;
  logic [ADDR_W-1:0] addr_q;
  logic [IO_W-1:0]   sw_q;

  logic              accept_c;
  logic              ram_we_c;
  logic              ready_n;
  logic              resp_valid_n;
  logic              err_n;
  logic [DATA_W-1:0] read_data_n;
  logic [IO_W-1:0]   ledr_n;

  function automatic logic is_ram(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(RAM_WORDS);
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return is_ram(a) || (a == LED_ADDR) || (a == SW_ADDR);
  endfunction

  assign accept_c = req & ready & (mem_cmd != 2'b00);

  // RAM is never reset; its read port samples on every accepted request
  always_ff @(posedge clk) begin
    if (ram_we_c) ram[mem_addr[RAM_AW-1:0]] <= write_data;
    if (accept_c) ram_rd <= ram[mem_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      read_data  <= '0;
      ledr       <= '0;
      addr_q     <= '0;
      sw_q       <= '0;
    end else begin
      state      <= state_n;
      ready      <= ready_n;
      resp_valid <= resp_valid_n;
      err        <= err_n;
      read_data  <= read_data_n;
      ledr       <= ledr_n;
      if (accept_c) begin
        addr_q <= mem_addr;
        sw_q   <= sw_in;
      end
    end
  end

  // Writes and reserved commands respond one cycle after accept; reads two
  always_comb begin
    state_n      = state;
    resp_valid_n = 1'b0;
    err_n        = 1'b0;
    read_data_n  = read_data;
    ledr_n       = ledr;
    ram_we_c     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          case (mem_cmd)
            CMD_READ: state_n = RD_ACCESS;
            CMD_WRITE: begin
              state_n      = RESP;
              resp_valid_n = 1'b1;
              err_n        = !is_mapped(mem_addr);
              ram_we_c     = is_ram(mem_addr);
              if (mem_addr == LED_ADDR) ledr_n = write_data[IO_W-1:0];
            end
            default: begin
              state_n      = RESP;
              resp_valid_n = 1'b1;
              err_n        = 1'b1;
            end
          endcase
        end
      end
      RD_ACCESS: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        if (is_ram(addr_q))           read_data_n = ram_rd;
        else if (addr_q == LED_ADDR)  read_data_n = DATA_W'(ledr);
        else if (addr_q == SW_ADDR)   read_data_n = DATA_W'(sw_q);
        else begin
          read_data_n = '0;
          err_n       = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

endmodule
